// File: rtl/iir_cascade_tdm.sv
// Cascade of NUM_STAGES direct-form-I biquads sharing one time-multiplexed MAC,
// with a shadow/active coefficient bank, per-sample bypass and sticky saturation flags.
`timescale 1ns/1ps
module iir_cascade_tdm #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18,
    parameter int NUM_STAGES  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_in,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  iir_in,
    input  logic [NUM_STAGES-1:0]  bypass,
    input  logic                   coeff_wr_en,
    input  logic [2:0]             coeff_stage,
    input  logic [2:0]             coeff_idx,
    input  logic [COEFF_WIDTH-1:0] coeff_data,
    input  logic                   coeff_commit,
    output logic                   commit_pending,
    input  logic                   flag_clr,
    output logic [DATA_WIDTH-1:0]  iir_out,
    output logic                   valid_out,
    output logic [NUM_STAGES-1:0]  overflow,
    output logic [NUM_STAGES-1:0]  underflow
);

    localparam int ACC_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 3;
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int MAX_STAGES = 8;
    localparam int NUM_COEFFS = 5;
    // Products carry DATA_FRAC+COEFF_FRAC fraction bits; writeback returns to DATA_FRAC.
    localparam int WB_SHIFT = (DATA_FRAC + COEFF_FRAC) - DATA_FRAC;
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) << (WB_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [COEFF_WIDTH-1:0] B0_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, STAGE, DONE} state_t;

    state_t                        state;
    logic [2:0]                    stage_idx;
    logic [2:0]                    mac_step;
    logic [NUM_STAGES-1:0]         byp_lat;
    logic signed [DATA_WIDTH-1:0]  stage_in;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [DATA_WIDTH-1:0]  x1 [MAX_STAGES];
    logic signed [DATA_WIDTH-1:0]  x2 [MAX_STAGES];
    logic signed [DATA_WIDTH-1:0]  y1 [MAX_STAGES];
    logic signed [DATA_WIDTH-1:0]  y2 [MAX_STAGES];
    logic signed [COEFF_WIDTH-1:0] coef_act [MAX_STAGES][NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] coef_shd [MAX_STAGES][NUM_COEFFS];
    logic signed [COEFF_WIDTH-1:0] shd_next [MAX_STAGES][NUM_COEFFS];

    logic                          cur_bypass;
    logic signed [COEFF_WIDTH-1:0] mac_coef;
    logic signed [DATA_WIDTH-1:0]  mac_data;
    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [ACC_WIDTH-1:0]   rounded;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic                          sat_hi;
    logic                          sat_lo;
    logic signed [DATA_WIDTH-1:0]  sat_val;
    logic                          writeback;
    logic [NUM_STAGES-1:0]         ovf_set;
    logic [NUM_STAGES-1:0]         unf_set;
    logic                          wr_ok;
    logic                          do_commit;

    assign in_ready  = (state == IDLE);
    assign wr_ok     = coeff_wr_en && ({1'b0, coeff_stage} < 4'(NUM_STAGES)) && (coeff_idx <= 3'd4);
    assign do_commit = (state == IDLE) && (commit_pending || coeff_commit);
    assign writeback = (state == STAGE) && !cur_bypass && (mac_step == 3'd5);

    // The write of this cycle is merged before any commit so a same-cycle commit sees it.
    always_comb begin
        shd_next = coef_shd;
        if (wr_ok) shd_next[coeff_stage][coeff_idx] = coeff_data;
    end

    always_comb begin
        cur_bypass = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (stage_idx == 3'(i)) cur_bypass = byp_lat[i];
    end

    always_comb begin
        mac_coef = '0;
        mac_data = '0;
        case (mac_step)
            3'd0: begin mac_coef = coef_act[stage_idx][0]; mac_data = stage_in;       end
            3'd1: begin mac_coef = coef_act[stage_idx][1]; mac_data = x1[stage_idx];  end
            3'd2: begin mac_coef = coef_act[stage_idx][2]; mac_data = x2[stage_idx];  end
            3'd3: begin mac_coef = coef_act[stage_idx][3]; mac_data = y1[stage_idx];  end
            3'd4: begin mac_coef = coef_act[stage_idx][4]; mac_data = y2[stage_idx];  end
            default: ;
        endcase
        product = PROD_WIDTH'(mac_coef) * PROD_WIDTH'(mac_data);
        case (mac_step)
            3'd0:       acc_next = ACC_WIDTH'(product);
            3'd1, 3'd2: acc_next = acc + ACC_WIDTH'(product);
            3'd3, 3'd4: acc_next = acc - ACC_WIDTH'(product);
            default:    acc_next = acc;
        endcase
    end

    always_comb begin
        rounded = acc + ROUND_BIAS;
        shifted = rounded >>> WB_SHIFT;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        if (sat_hi)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
        else if (sat_lo) sat_val = SAT_MIN[DATA_WIDTH-1:0];
        else             sat_val = shifted[DATA_WIDTH-1:0];
        ovf_set = '0;
        unf_set = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (writeback && stage_idx == 3'(i)) begin
                ovf_set[i] = sat_hi;
                unf_set[i] = sat_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            stage_idx      <= '0;
            mac_step       <= '0;
            byp_lat        <= '0;
            stage_in       <= '0;
            acc            <= '0;
            iir_out        <= '0;
            valid_out      <= 1'b0;
            overflow       <= '0;
            underflow      <= '0;
            commit_pending <= 1'b0;
            for (int s = 0; s < MAX_STAGES; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
                for (int k = 0; k < NUM_COEFFS; k++) begin
                    coef_act[s][k] <= (k == 0) ? B0_ONE : '0;
                    coef_shd[s][k] <= (k == 0) ? B0_ONE : '0;
                end
            end
        end else begin
            valid_out <= 1'b0;
            coef_shd  <= shd_next;
            if (do_commit) begin
                coef_act       <= shd_next;
                commit_pending <= 1'b0;
            end else if (coeff_commit) begin
                commit_pending <= 1'b1;
            end
            overflow  <= (flag_clr ? '0 : overflow)  | ovf_set;
            underflow <= (flag_clr ? '0 : underflow) | unf_set;

            case (state)
                IDLE: begin
                    if (valid_in) begin
                        stage_in  <= iir_in;
                        byp_lat   <= bypass;
                        stage_idx <= '0;
                        mac_step  <= '0;
                        state     <= STAGE;
                    end
                end
                STAGE: begin
                    if (cur_bypass || mac_step == 3'd5) begin
                        if (!cur_bypass) begin
                            x2[stage_idx] <= x1[stage_idx];
                            x1[stage_idx] <= stage_in;
                            y2[stage_idx] <= y1[stage_idx];
                            y1[stage_idx] <= sat_val;
                            stage_in      <= sat_val;
                        end
                        mac_step <= '0;
                        if (stage_idx == LAST_STAGE) state <= DONE;
                        else                         stage_idx <= stage_idx + 3'd1;
                    end else begin
                        acc      <= acc_next;
                        mac_step <= mac_step + 3'd1;
                    end
                end
                DONE: begin
                    valid_out <= 1'b1;
                    iir_out   <= stage_in;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/iir_cascade_tdm.md
Name: iir_cascade_tdm

Overview:
- Parametrised successor of the fixed three-notch IIR chain.
- Runs NUM_STAGES direct-form-I biquads one after another on a single time-multiplexed multiply-accumulate unit.
- Adds:
  - ready/valid input handshake;
  - an addressed shadow coefficient bank with an atomic commit;
  - a bypass vector that is latched per sample;
  - per-stage sticky overflow/underflow flags.
- Sits in the DFE datapath where the IIR chain sits.

Parameters:
- DATA_WIDTH, 16, sample width (signed).
- DATA_FRAC, 15, fractional bits of the sample.
- COEFF_WIDTH, 20, coefficient width (signed).
- COEFF_FRAC, 18, fractional bits of the coefficient.
- NUM_STAGES, 3, number of cascaded biquads, 1..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- iir_in  in  DATA_WIDTH  input sample.
- bypass  in  NUM_STAGES  per-stage bypass; bit i controls stage i.
- coeff_wr_en  in  1  write the shadow coefficient bank.
- coeff_stage  in  3  target stage index.
- coeff_idx  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coeff_data  in  COEFF_WIDTH  coefficient value.
- coeff_commit  in  1  request copy of shadow bank to active bank.
- commit_pending  out  1  commit requested but not yet applied.
- flag_clr  in  1  clear sticky flags.
- iir_out  out  DATA_WIDTH  output sample.
- valid_out  out  1  one-cycle output strobe.
- overflow  out  NUM_STAGES  sticky positive saturation, one bit per stage.
- underflow  out  NUM_STAGES  sticky negative saturation, one bit per stage.

Behaviour:
- Reset values:
  - FSM in IDLE; in_ready=1; valid_out=0; iir_out=0.
  - overflow=0; underflow=0; commit_pending=0.
  - All delay lines (x1, x2, y1, y2 of every stage) are 0.
  - Active and shadow banks: b0 = 1<<COEFF_FRAC, all other coefficients 0 (passthrough).
- Reset mid-sample aborts the computation and restores all of the above.
- Acceptance:
  - A sample is accepted when valid_in && in_ready.
  - iir_in and bypass are latched at acceptance.
  - in_ready=1 only in IDLE.
- FSM: IDLE -> STAGE -> DONE -> IDLE.
- STAGE processing, stage index s = 0..NUM_STAGES-1:
  - Not bypassed: 5 MAC cycles in the order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2, then 1 writeback cycle (6 cycles total).
  - Bypassed: 1 cycle. Stage output = stage input; delay lines hold.
- Arithmetic:
  - Accumulator width is DATA_WIDTH+COEFF_WIDTH+3, full precision.
  - Writeback: add 1<<(COEFF_FRAC-1), arithmetic shift right by COEFF_FRAC, then saturate to DATA_WIDTH.
  - Saturated result becomes the stage output and the next stage input.
  - Writeback updates: x2<=x1, x1<=x, y2<=y1, y1<=saturated result.
  - Saturation sets overflow[s] or underflow[s] (sticky).
- DONE (1 cycle):
  - valid_out=1 and iir_out = final stage output.
  - iir_out holds its value until the next DONE.
- Latency:
  - valid_out is high N cycles after the acceptance edge.
  - N = sum over stages (bypass ? 1 : 6) + 1.
  - Default configuration, no bypass: 19 cycles.
  - Next acceptance is possible at the cycle after DONE.
- Coefficient write:
  - Writes the shadow bank only; allowed in any state.
  - A write with coeff_stage >= NUM_STAGES or coeff_idx > 4 is ignored.
- Commit:
  - coeff_commit sets commit_pending.
  - Shadow-to-active copy happens on the first IDLE cycle; commit_pending clears on that same cycle.
  - An acceptance in that same cycle uses the new coefficients.
  - The active bank never changes mid-sample.
- Simultaneous commit and write in one cycle: the write lands in shadow first, and the copy in that cycle includes it.
- Flags:
  - flag_clr clears all flags.
  - Simultaneous set and clear in the same cycle: set wins.
- valid_in while busy is ignored. It is not queued; the upstream block holds the sample.

Test Plan:
- Reset defaults, no bypass: accept iir_in=0x4000 -> valid_out exactly 19 cycles later with iir_out=0x4000; flags 0.
- Shadow write stage0 b0=0x20000, commit in IDLE: input 0x4000 -> 0x2000. Commit issued mid-sample: that sample still outputs 0x4000, the next outputs 0x2000, commit_pending high until the IDLE cycle.
- Feedback: stage0 b0=0x40000, a1=0xE0000 (-0.5). Impulse 0x4000 then zeros -> outputs 0x4000, 0x2000, 0x1000, 0x0800.
- Saturation: stage0 b0=0x7FFFF, input 0x7FFF -> iir_out=0x7FFF, overflow=3'b001 persists; flag_clr -> 0. Input 0x8000 with b0=0x7FFFF -> underflow[0]=1.
- Bypass=3'b111 -> latency 4 and output equals input. Bypass=3'b010 -> latency 14. Changing bypass mid-sample has no effect on the in-flight sample.
- valid_in held high continuously -> one acceptance per 20 cycles, in_ready low from acceptance through DONE. rst_n low mid-STAGE -> valid_out never fires, delay lines 0, in_ready=1.
